// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the IF/MEM memory port arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int STARVE_W = 3;
  localparam int LAT_W    = 3;

endpackage

// File: rtl/arb_starve_ctr.sv
// Grant decision between fetch and data ports plus the fetch starvation counter.
module arb_starve_ctr
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                idle_i,
  input  logic                if_req_i,
  input  logic                dm_req_i,
  output logic                grant_vld_o,
  output logic                grant_if_o,
  output logic [STARVE_W-1:0] starve_cnt_o
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;

  // Data wins ties unless fetch has already lost STARVE_MAX times in a row.
  assign grant_vld_o  = if_req_i | dm_req_i;
  assign grant_if_o   = if_req_i & (~dm_req_i | (starve_q >= STARVE_MAX_C));
  assign starve_cnt_o = starve_q;

  always_comb begin
    starve_d = starve_q;
    if (idle_i) begin
      if (!if_req_i || grant_if_o) begin
        starve_d = '0;
      end else if (starve_q != '1) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) starve_q <= '0;
    else         starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports
// of the pipeline, one fixed-latency access at a time.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's command
// ISSUE | mem_en strobe for the latched command
// WAIT  | count down memory latency; capture read data on the last cycle
// RESP  | one-cycle ready pulse to the owner
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_if_o,
  output logic        stall_mem_o
);

  arb_state_e         state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               own_q, own_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        dm_rdata_q, dm_rdata_d;

  logic               grant_vld;
  logic               grant_if;
  logic [STARVE_W-1:0] starve_cnt;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .idle_i       (state_q == ST_IDLE),
    .if_req_i     (if_req_i),
    .dm_req_i     (dm_req_i),
    .grant_vld_o  (grant_vld),
    .grant_if_o   (grant_if),
    .starve_cnt_o (starve_cnt)
  );

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    own_d      = own_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          if (grant_if) begin
            own_d   = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end else begin
            own_d   = OWN_DM;
            we_d    = dm_we_i;
            addr_d  = dm_addr_i;
            wdata_d = dm_wdata_i;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_d   = LAT_W'(MEM_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          if (own_q == OWN_IF)  if_rdata_d = mem_rdata_i;
          else if (!we_q)       dm_rdata_d = mem_rdata_i;
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      own_q      <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      own_q      <= own_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en_o    = (state_q == ST_ISSUE);
  assign mem_we_o    = mem_en_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_ready_o  = (state_q == ST_RESP) && (own_q == OWN_IF);
  assign dm_ready_o  = (state_q == ST_RESP) && (own_q == OWN_DM);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

  assign stall_if_o  = if_req_i & ~if_ready_o;
  assign stall_mem_o = dm_req_i & ~dm_ready_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=1 and a behavioural memory.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o;
  logic        stall_mem_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ready_o  (if_ready_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ready_o  (dm_ready_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o)
  );

  // One-cycle read latency memory.
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
      else          mem_rdata_i <= mem[mem_addr_o[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]      = 32'h0010_0093;
    mem[5]      = 32'h1234_5678;
    mem_rdata_i = 32'h0;
    rstn_i     = 1'b0;
    if_req_i   = 1'b0;
    if_addr_i  = 32'h0;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    dm_addr_i  = 32'h0;
    dm_wdata_i = 32'h0;

    repeat (2) tick();
    chk("rst_mem_en",   mem_en_o,   0);
    chk("rst_if_ready", if_ready_o, 0);
    chk("rst_dm_ready", dm_ready_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_dm_rdata", dm_rdata_o, 0);
    rstn_i = 1'b1;
    tick();

    // single fetch
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0010;
    #1;
    chk("f_stall_c0", stall_if_o, 1);
    tick();
    chk("f_mem_en_c1", mem_en_o,   1);
    chk("f_addr_c1",   mem_addr_o, 32'h10);
    chk("f_we_c1",     mem_we_o,   0);
    chk("f_stall_c1",  stall_if_o, 1);
    tick();
    chk("f_mem_en_c2", mem_en_o,   0);
    chk("f_ready_c2",  if_ready_o, 0);
    chk("f_stall_c2",  stall_if_o, 1);
    tick();
    chk("f_ready_c3",  if_ready_o, 1);
    chk("f_rdata_c3",  if_rdata_o, 32'h0010_0093);
    chk("f_stall_c3",  stall_if_o, 0);
    if_req_i = 1'b0;
    tick();
    chk("f_ready_c4",  if_ready_o, 0);
    chk("f_hold_c4",   if_rdata_o, 32'h0010_0093);

    // store then back-to-back load to the same address
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h200;
    dm_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk("s_stall_c0", stall_mem_o, 1);
    tick();
    chk("s_mem_en_c1", mem_en_o,    1);
    chk("s_we_c1",     mem_we_o,    1);
    chk("s_wdata_c1",  mem_wdata_o, 32'hDEAD_BEEF);
    chk("s_addr_c1",   mem_addr_o,  32'h200);
    tick();
    tick();
    chk("s_ready_c3",  dm_ready_o,  1);
    chk("s_stall_c3",  stall_mem_o, 0);
    dm_we_i = 1'b0;
    tick();
    chk("l_ready_c4",  dm_ready_o,  0);
    tick();
    chk("l_mem_en_c5", mem_en_o,    1);
    chk("l_we_c5",     mem_we_o,    0);
    tick();
    tick();
    chk("l_ready_c7",  dm_ready_o,  1);
    chk("l_rdata_c7",  dm_rdata_o,  32'hDEAD_BEEF);
    chk("l_if_hold",   if_rdata_o,  32'h0010_0093);
    dm_req_i = 1'b0;
    tick();

    // simultaneous requests: data first, then fetch
    if_req_i  = 1'b1;
    if_addr_i = 32'h14;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h200;
    repeat (3) tick();
    chk("sim_dm_ready_c3", dm_ready_o, 1);
    chk("sim_if_ready_c3", if_ready_o, 0);
    dm_req_i = 1'b0;
    repeat (3) tick();
    chk("sim_if_ready_c6", if_ready_o, 0);
    tick();
    chk("sim_if_ready_c7", if_ready_o, 1);
    chk("sim_if_rdata_c7", if_rdata_o, 32'h1234_5678);
    if_req_i = 1'b0;
    tick();

    // fetch data held across data accesses
    for (int k = 0; k < 3; k++) begin
      dm_req_i   = 1'b1;
      dm_we_i    = (k != 1);
      dm_addr_i  = 32'h300 + 32'(4 * k);
      dm_wdata_i = 32'hA5A5_0000 + 32'(k);
      repeat (3) tick();
      chk("hold_dm_ready", dm_ready_o, 1);
      chk("hold_if_rdata", if_rdata_o, 32'h1234_5678);
      dm_req_i = 1'b0;
      tick();
    end
    chk("hold_dm_rdata", dm_rdata_o, 32'h0);

    // starvation: data wins four times, fifth grant goes to fetch
    if_req_i  = 1'b1;
    if_addr_i = 32'h10;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h200;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("stv_cnt", 32'(dut.u_starve.starve_cnt_o), (g < 4) ? 32'(g + 1) : 32'd0);
      tick();
      tick();
      chk("stv_dm_ready", dm_ready_o, (g < 4) ? 32'd1 : 32'd0);
      chk("stv_if_ready", if_ready_o, (g == 4) ? 32'd1 : 32'd0);
      if (g == 4) begin
        chk("stv_if_rdata", if_rdata_o, 32'h0010_0093);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
      end
      tick();
    end

    // reset asserted while a fetch is in WAIT
    if_req_i  = 1'b1;
    if_addr_i = 32'h14;
    tick();
    tick();
    chk("ra_in_wait", 32'(dut.state_q), 32'd2);
    rstn_i = 1'b0;
    #1;
    chk("ra_mem_en",   mem_en_o,   0);
    chk("ra_if_ready", if_ready_o, 0);
    chk("ra_state",    32'(dut.state_q), 0);
    if_req_i = 1'b0;
    tick();
    chk("ra_state_c1", 32'(dut.state_q), 0);
    chk("ra_dm_ready", dm_ready_o, 0);
    chk("ra_if_rdata", if_rdata_o, 0);
    rstn_i = 1'b1;
    pulses = 0;
    repeat (8) begin
      tick();
      if (if_ready_o || dm_ready_o) pulses++;
    end
    chk("ra_no_pulse", 32'(pulses), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
